// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and state type for the SPI responder.
package spi_pkg;
    localparam int SPI_DATA_WIDTH = 8;
    localparam int MIN_SYNC_STAGES = 2;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer with one-cycle rise/fall pulses.
module sync_edge_detect
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    logic [STAGES-1:0] chain;
    logic prev;
    always_ff @(posedge clk_in) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end
    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: mode-0 SPI responder with one-entry transmit buffer.
// SPI_SLAVE_LSB_FIRST_EN selects LSB-first order in both directions (default MSB first).
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun
);
    localparam int CW = $clog2(DATA_WIDTH);
    state_t state, state_next;
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
    logic [DATA_WIDTH-1:0] rx_shift, tx_shift, buf_data, rx_next, tx_next, load_word;
    logic [CW-1:0] bit_cnt;
    logic buf_full, reload, do_load, do_rx, do_tx, wrap, wr, load_head, next_head;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk_in(clk_in), .reset(reset), .din(sclk),
        .sync(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk_in(clk_in), .reset(reset), .din(cs_n),
        .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clk_in(clk_in), .reset(reset), .din(mosi),
        .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign wrap      = bit_cnt == CW'(DATA_WIDTH - 1);
    assign tx_ready  = ~buf_full;
    assign wr        = tx_valid & ~buf_full;
    assign load_word = buf_full ? buf_data : '0;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next   = {mosi_sync, rx_shift[DATA_WIDTH-1:1]};
    assign tx_next   = tx_shift >> 1;
    assign load_head = load_word[0];
    assign next_head = tx_next[0];
`else
    assign rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_sync};
    assign tx_next   = tx_shift << 1;
    assign load_head = load_word[DATA_WIDTH-1];
    assign next_head = tx_next[DATA_WIDTH-1];
`endif

    always_ff @(posedge clk_in) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // cs_n rise overrides everything, so a simultaneous sclk edge is dropped
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_rx      = 1'b0;
        do_tx      = 1'b0;
        if (cs_rise) state_next = IDLE;
        else case (state)
            IDLE:  if (cs_fall) state_next = LOAD;
            LOAD: begin
                do_load    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                do_rx   = sclk_rise & ~cs_sync;
                do_load = sclk_fall & ~cs_sync & reload;
                do_tx   = sclk_fall & ~cs_sync & ~reload;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            bit_cnt     <= '0;
            reload      <= 1'b0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso        <= 1'b0;
        end else begin
            rx_valid    <= do_rx & wrap;
            tx_underrun <= do_load & ~buf_full;
            // a write in the load cycle lands after the load has emptied the buffer
            buf_full    <= wr | (buf_full & ~do_load);
            if (wr) buf_data <= tx_data;
            if (do_load) begin
                tx_shift <= load_word;
                miso     <= load_head;
            end else if (do_tx) begin
                tx_shift <= tx_next;
                miso     <= next_head;
            end
            if (cs_rise) begin
                bit_cnt  <= '0;
                reload   <= 1'b0;
                rx_shift <= '0;
            end else begin
                if (do_rx) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= wrap ? '0 : bit_cnt + 1'b1;
                    if (wrap) begin
                        rx_data <= rx_next;
                        reload  <= 1'b1;
                    end
                end
                if (do_load) reload <= 1'b0;
            end
        end
    end
endmodule
